// File: rtl/lcd_cmd_sequencer.sv
// LCD_CTRL host-side command sequencer: FIFO-buffered command issue,
// busy/done handshake, busy timeout and IRAM write monitor.
//
// Ports:
//   clk, reset          clock (rising edge), async active-high reset
//   s_cmd/s_valid/s_ready  upstream command push (push = s_valid & s_ready)
//   cmd/cmd_valid       code and one-cycle issue strobe to LCD controller
//   busy, done          controller status inputs
//   IRAM_valid/A/D      monitored controller IRAM write port
//   wr_count            IRAM writes this session, saturating at 64
//   seq_done, cmd_err, tmo_err  sticky status flags
//   checksum            16-bit wrapping sum of written IRAM_D bytes
//
// Optional feature macro: LCD_SEQ_CHECKSUM_EN (checksum is 0 when undefined).
module lcd_cmd_sequencer #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TMO_CYC = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  s_cmd,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [3:0]  cmd,
    output logic        cmd_valid,
    input  logic        busy,
    input  logic        done,
    input  logic        IRAM_valid,
    input  logic [5:0]  IRAM_A,
    input  logic [7:0]  IRAM_D,
    output logic [6:0]  wr_count,
    output logic        seq_done,
    output logic        cmd_err,
    output logic        tmo_err,
    output logic [15:0] checksum
);

    typedef enum logic [2:0] {
        IDLE, ISSUE, HOLD, WAIT, WAIT_DONE, FIN
    } state_t;

    localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
    localparam logic [9:0]  TMO_LAST = 10'(TMO_CYC - 1);

    state_t          state;
    logic [3:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            push;
    logic            pop;
    logic [3:0]      head;
    logic [9:0]      tmo_cnt;
    logic            wr_sat;

    // s_ready reflects the pre-pop count, so a full FIFO refuses a push
    // even in the cycle it is popped.
    assign s_ready = (count != FULL);
    assign push    = s_valid & s_ready;
    assign head    = mem[rd_ptr];
    assign pop     = (state == IDLE) & (count != '0) & ~busy & ~seq_done;
    assign wr_sat  = (wr_count == 7'd64);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s_cmd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            seq_done  <= 1'b0;
            cmd_err   <= 1'b0;
            tmo_err   <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        if (head > 4'd11) begin
                            cmd_err <= 1'b1;
                        end else begin
                            cmd       <= head;
                            cmd_valid <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    cmd_valid <= 1'b0;
                    state     <= HOLD;
                end
                // busy rises at the issue edge; skip sampling it here
                HOLD: begin
                    tmo_cnt <= '0;
                    state   <= (cmd == 4'd0) ? WAIT_DONE : WAIT;
                end
                WAIT: begin
                    if (!busy) begin
                        state <= IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_err  <= 1'b1;
                        seq_done <= 1'b1;
                        state    <= FIN;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (done) begin
                        seq_done <= 1'b1;
                        state    <= FIN;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_err  <= 1'b1;
                        seq_done <= 1'b1;
                        state    <= FIN;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                FIN: begin
                    cmd_valid <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wr_count <= '0;
        else if (IRAM_valid && !wr_sat)
            wr_count <= wr_count + 1'b1;
    end

`ifdef LCD_SEQ_CHECKSUM_EN
    logic unused_iram;
    assign unused_iram = ^IRAM_A;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            checksum <= '0;
        else if (IRAM_valid && !wr_sat)
            checksum <= checksum + {8'h00, IRAM_D};
    end
`else
    logic unused_iram;
    assign unused_iram = ^{IRAM_A, IRAM_D};
    assign checksum    = 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Bench for lcd_cmd_sequencer: controller responder, issue scoreboard,
// directed session scenarios.
module tb_lcd_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  s_cmd;
    logic        s_valid;
    logic        s_ready;
    logic [3:0]  cmd;
    logic        cmd_valid;
    logic        busy;
    logic        done;
    logic        IRAM_valid;
    logic [5:0]  IRAM_A;
    logic [7:0]  IRAM_D;
    logic [6:0]  wr_count;
    logic        seq_done;
    logic        cmd_err;
    logic        tmo_err;
    logic [15:0] checksum;

    logic        bm;
    logic        bf;
    int          busy_len;
    logic [3:0]  exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          nstrobe = 0;
    int          base;
    logic [15:0] exp_ck;

    assign busy = bm | bf;

    always #5 clk = ~clk;

    lcd_cmd_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .s_cmd      (s_cmd),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .done       (done),
        .IRAM_valid (IRAM_valid),
        .IRAM_A     (IRAM_A),
        .IRAM_D     (IRAM_D),
        .wr_count   (wr_count),
        .seq_done   (seq_done),
        .cmd_err    (cmd_err),
        .tmo_err    (tmo_err),
        .checksum   (checksum)
    );

    task automatic check(string name, logic [15:0] act, logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(logic [3:0] c, bit issue);
        @(negedge clk);
        s_cmd   = c;
        s_valid = 1'b1;
        if (issue)
            exp_q.push_back(c);
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_q(string name, int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Controller responder: busy rises at the issue edge for busy_len
    // cycles; a WRITE (code 0) finishes with a one-cycle done pulse.
    initial begin : ctrl
        logic [3:0] c;
        bm   = 1'b0;
        done = 1'b0;
        forever begin
            @(negedge clk);
            if (cmd_valid) begin
                c = cmd;
                @(posedge clk);
                #1 bm = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 bm = 1'b0;
                if (c == 4'd0)
                    done = 1'b1;
                @(posedge clk);
                #1 done = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every strobe must match the next expected code
    // and must never coincide with busy.
    initial begin : mon
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (cmd_valid) begin
                nstrobe++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL strobe_unexpected cmd=%0d required=none", cmd);
                end else begin
                    e = exp_q.pop_front();
                    if (cmd !== e) begin
                        bad++;
                        $display("FAIL strobe_code cmd=%0d required=%0d", cmd, e);
                    end
                end
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL strobe_busy busy=%b required=0", busy);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog time_limit reached required=finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        s_valid    = 1'b0;
        s_cmd      = '0;
        bf         = 1'b1;
        busy_len   = 2;
        IRAM_valid = 1'b0;
        IRAM_A     = '0;
        IRAM_D     = '0;
`ifdef LCD_SEQ_CHECKSUM_EN
        exp_ck = 16'h07E0;
`else
        exp_ck = 16'h0000;
`endif
        repeat (3) @(negedge clk);
        check("rst_s_ready", s_ready, 1);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd", cmd, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_seq_done", seq_done, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_tmo_err", tmo_err, 0);
        check("rst_checksum", checksum, 0);

        // 1: busy high after reset, script 1,4,0, then session end
        reset = 1'b0;
        push(4'd1, 1);
        push(4'd4, 1);
        push(4'd0, 1);
        repeat (130) @(posedge clk);
        #1;
        check("t1_held_strobes", nstrobe, 0);
        check("t1_held_seq_done", seq_done, 0);
        @(negedge clk);
        bf = 1'b0;
        wait_q("t1_issue", 200);
        for (int n = 0; n < 20 && !seq_done; n++)
            @(posedge clk);
        #1;
        check("t1_seq_done", seq_done, 1);
        base = nstrobe;
        push(4'd5, 0);
        repeat (20) @(posedge clk);
        #1;
        check("t1_fin_no_issue", nstrobe - base, 0);

        // 2: fill FIFO past full while busy held
        bf = 1'b1;
        do_reset();
        for (int i = 0; i < 16; i++)
            push(4'((i % 11) + 1), 1);
        check("t2_full_ready", s_ready, 0);
        push(4'd9, 0);
        check("t2_full_after17", s_ready, 0);
        base = nstrobe;
        @(negedge clk);
        bf = 1'b0;
        wait_q("t2_issue", 300);
        repeat (20) @(posedge clk);
        #1;
        check("t2_issue_count", nstrobe - base, 16);
        check("t2_s_ready", s_ready, 1);

        // 3: illegal code dropped, next legal one issued
        do_reset();
        check("t3_err_clear", cmd_err, 0);
        base = nstrobe;
        push(4'd13, 0);
        push(4'd2, 1);
        wait_q("t3_issue", 50);
        repeat (10) @(posedge clk);
        #1;
        check("t3_cmd_err", cmd_err, 1);
        check("t3_issue_count", nstrobe - base, 1);

        // 4: issue latency and back-to-back codes around busy
        do_reset();
        push(4'd7, 1);
        check("t4_lat_early", cmd_valid, 0);
        @(posedge clk);
        #1;
        check("t4_lat_valid", cmd_valid, 1);
        check("t4_lat_cmd", cmd, 7);
        push(4'd3, 1);
        wait_q("t4_issue", 50);
        repeat (10) @(posedge clk);
        #1;
        check("t4_cmd_hold", cmd, 3);
        check("t4_seq_done", seq_done, 0);

        // 5: busy stuck high -> timeout ends the session
        do_reset();
        busy_len = 1100;
        base = nstrobe;
        push(4'd5, 1);
        wait_q("t5_issue", 10);
        repeat (1000) @(posedge clk);
        #1;
        check("t5_tmo_early", tmo_err, 0);
        repeat (40) @(posedge clk);
        #1;
        check("t5_tmo_err", tmo_err, 1);
        check("t5_seq_done", seq_done, 1);
        push(4'd6, 0);
        repeat (120) @(posedge clk);
        #1;
        check("t5_issue_count", nstrobe - base, 1);
        busy_len = 2;

        // 6: IRAM monitor, saturation and reset mid-stream
        bf = 1'b1;
        do_reset();
        push(4'd3, 0);
        push(4'd4, 0);
        push(4'd5, 0);
        for (int a = 0; a < 64; a++) begin
            @(negedge clk);
            IRAM_valid = 1'b1;
            IRAM_A     = 6'(a);
            IRAM_D     = 8'(a);
        end
        for (int a = 0; a < 3; a++) begin
            @(negedge clk);
            IRAM_valid = 1'b1;
            IRAM_D     = 8'hFF;
        end
        @(negedge clk);
        IRAM_valid = 1'b0;
        check("t6_wr_count", wr_count, 64);
        check("t6_checksum", checksum, exp_ck);
        IRAM_valid = 1'b1;
        IRAM_D     = 8'h55;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t6_rst_wr_count", wr_count, 0);
        check("t6_rst_checksum", checksum, 0);
        check("t6_rst_s_ready", s_ready, 1);
        check("t6_rst_cmd_valid", cmd_valid, 0);
        @(negedge clk);
        IRAM_valid = 1'b0;
        reset      = 1'b0;
        bf         = 1'b0;
        base       = nstrobe;
        repeat (20) @(posedge clk);
        #1;
        check("t6_fifo_flushed", nstrobe - base, 0);
        check("t6_wr_count_after", wr_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
